vec_mem_stage_mp: RTL and testbench
===================================

Name: vec_mem_stage_mp

Overview:
Multi-lane memory stage for the vector ASIP. It moves scalar or vector operands between the pipeline and an item-addressed data memory, transferring P items per beat instead of one. A start/busy/done handshake allows the pipeline to stall around multi-beat transfers. It sits between the execute stage (aluResult*, rd2_*) and writeback, and drives the external data-memory port.

Parameters:
I, 20, items per vector
L, 8, item width in bits
A, 6, item address width (memory depth 2^A items)
P, 4, lanes (items) per memory beat, 1 <= P <= I

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request, sampled only in IDLE
op_type  in  1  0 = scalar, 1 = vector
op_source  in  1  store data source: 1 = aluResult*, 0 = rd2_*
write_enable  in  1  1 = store, 0 = load
address  in  A  base item address
aluResultV  in  I*L  vector ALU result
rd2_vec  in  I*L  vector register operand 2
aluResultS  in  L  scalar ALU result
rd2_sca  in  L  scalar register operand 2
mem_rdata  in  P*L  memory read data, valid 1 cycle after its address
mem_addr  out  A  beat base item address
mem_wdata  out  P*L  beat write data, lane 0 = item at mem_addr
mem_we  out  1  write strobe
mem_be  out  P  per-lane enable (applies to reads and writes)
scalar_output  out  L  last scalar load result
vector_output  out  I*L  last vector load result
busy  out  1  transfer in progress
mem_finished  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst=0): FSM=IDLE. All outputs 0, including mem_we, busy and the load registers. Mid-transfer reset aborts immediately, with no further beats and no done pulse.
- N = ceil(I/P) beats for a vector op; 1 beat for a scalar op.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: on start=1, latch op_type, write_enable and address. Snapshot the store source selected by op_source. Clear beat counter k=0, set busy=1, then go to WRITE (store) or READ (load).
- WRITE: each cycle, mem_addr = (address + k*P) mod 2^A, mem_we=1, mem_wdata = items k*P..k*P+P-1, k++. After beat N-1, go to DONE.
- READ: each cycle, drive mem_addr and mem_be for beat k with mem_we=0, k++. Lanes from beat k-1 are captured into vector_output at the same edge. After beat N-1, go to DRAIN.
- DRAIN: capture the final beat, then go to DONE.
- DONE: mem_finished=1 and busy=0 for one cycle, then return to IDLE.
- Latency from the start edge to the mem_finished cycle: store N+1 cycles, load N+2 cycles. Scalar store takes 2 cycles; scalar load takes 3.
- mem_be: all ones, except for the last vector beat when I mod P != 0, where only the low (I mod P) lanes are set. Scalar ops use mem_be = 1 (lane 0 only); scalar store data sits in lane 0 and scalar_output takes lane 0.
- Disabled lanes are not written into vector_output, and their mem_wdata is 0.
- Address arithmetic wraps modulo 2^A. Items within a beat are consecutive and wrap modulo 2^A (memory model's responsibility).
- start while busy or in DONE is ignored. No queueing.
- Inputs may change after the start edge; only the snapshot is used.
- vector_output and scalar_output hold their values until overwritten by a later load of the same type. Stores never modify them.
- mem_we is 0 in every state except WRITE.

Decomposition:
- Package vec_mem_pkg holds:
  - state enum
  - op encodings (OP_SCALAR/OP_VECTOR, SRC_ALU/SRC_RD2)
  - function num_beats(I,P)
  - function last_mask(I,P)
- Sub-module vec_mem_beat_gen: beat counter, wrapped address and mem_be generation, and last-beat flag.
- Lane packing and unpacking stays in the top level.

Test Plan:
- Vector store, I=20, P=4, address=8, op_source=1, aluResultV[i]=i+1 -> 5 beats, mem_addr 8,12,16,20,24, mem_be=4'b1111. Memory items 8..27 = 1..20. mem_finished in cycle 6 after start.
- Vector load, same memory -> addresses on cycles 1..5. mem_finished in cycle 7. vector_output[i]=i+1. busy high for cycles 1..6.
- P=3, vector store at address 0 -> 7 beats, last beat mem_be=3'b011 at mem_addr 18. Item 20 is untouched.
- Wrap: P=4, vector store at address 62 -> mem_addr 62,2,6,10,14. Items 62,63,0..17 written.
- Scalar store, rd2_sca=0xA5, op_source=0, address=5 -> one beat at 5, mem_be=0001, lane0=0xA5. A following scalar load from 5 gives scalar_output=0xA5 with mem_finished 3 cycles after start.
- Abort: rst low during beat 2 of a vector store -> mem_we, busy and outputs drop to 0 immediately with no mem_finished. A start after release runs a complete fresh transfer; a start pulsed mid-transfer is ignored.

Source files
------------

// File: rtl/vec_mem_pkg.sv
// Shared types and helpers for the multi-lane vector memory stage.
package vec_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic OP_SCALAR = 1'b0;
  localparam logic OP_VECTOR = 1'b1;
  localparam logic SRC_RD2   = 1'b0;
  localparam logic SRC_ALU   = 1'b1;

  function automatic int num_beats(input int i, input int p);
    return (i + p - 1) / p;
  endfunction

  // Lane mask for the final vector beat; a full beat when P divides I.
  function automatic logic [31:0] last_mask(input int i, input int p);
    int r;
    r = i % p;
    return (r == 0) ? ~(32'hFFFF_FFFF << p) : ~(32'hFFFF_FFFF << r);
  endfunction

endpackage

// File: rtl/vec_mem_beat_gen.sv
// Beat sequencer: counts beats, forms the wrapped beat address, lane enables and last flag.
module vec_mem_beat_gen
  import vec_mem_pkg::*;
#(
  parameter int I  = 20,
  parameter int P  = 4,
  parameter int A  = 6,
  parameter int NB = num_beats(I, P),
  parameter int KW = $clog2(NB + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          adv_i,
  input  logic          vec_i,
  input  logic [A-1:0]  base_i,
  output logic [KW-1:0] k_o,
  output logic [A-1:0]  addr_o,
  output logic [P-1:0]  be_o,
  output logic          last_o
);

  localparam logic [P-1:0] LAST_BE = P'(last_mask(I, P));

  logic [KW-1:0] k_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     k_q <= '0;
    else if (clr_i) k_q <= '0;
    else if (adv_i) k_q <= k_q + KW'(1);
  end

  assign k_o    = k_q;
  assign addr_o = base_i + A'(int'(k_q) * P);
  assign last_o = vec_i ? (k_q == KW'(NB - 1)) : 1'b1;
  assign be_o   = !vec_i ? P'(1) : (last_o ? LAST_BE : '1);

endmodule

// File: rtl/vec_mem_stage_mp.sv
// Multi-lane vector/scalar memory stage: moves P items per beat between pipeline and item memory.
module vec_mem_stage_mp
  import vec_mem_pkg::*;
#(
  parameter int I = 20,
  parameter int L = 8,
  parameter int A = 6,
  parameter int P = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           op_type,
  input  logic           op_source,
  input  logic           write_enable,
  input  logic [A-1:0]   address,
  input  logic [I*L-1:0] aluResultV,
  input  logic [I*L-1:0] rd2_vec,
  input  logic [L-1:0]   aluResultS,
  input  logic [L-1:0]   rd2_sca,
  input  logic [P*L-1:0] mem_rdata,
  output logic [A-1:0]   mem_addr,
  output logic [P*L-1:0] mem_wdata,
  output logic           mem_we,
  output logic [P-1:0]   mem_be,
  output logic [L-1:0]   scalar_output,
  output logic [I*L-1:0] vector_output,
  output logic           busy,
  output logic           mem_finished
);

  localparam int NB = num_beats(I, P);
  localparam int KW = $clog2(NB + 1);
  localparam int IL = I * L;
  localparam int PL = P * L;

  state_e        state_q;
  logic          op_q;
  logic [A-1:0]  addr_q;
  logic [IL-1:0] wd_q;
  logic [IL-1:0] vec_q;
  logic [L-1:0]  sca_q;
  logic          busy_q;
  logic          fin_q;
  logic          cap_vld_q;
  logic [KW-1:0] cap_k_q;
  logic [P-1:0]  cap_be_q;

  logic [KW-1:0] k;
  logic [A-1:0]  beat_addr;
  logic [P-1:0]  beat_be;
  logic          last;
  logic          active;
  logic [PL-1:0] wd_beat;
  logic [PL-1:0] rd_m;
  logic [PL-1:0] lane_m;
  logic [IL-1:0] vec_d;

  assign active = (state_q == S_WRITE) || (state_q == S_READ);

  vec_mem_beat_gen #(.I(I), .P(P), .A(A), .NB(NB), .KW(KW)) u_beat (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  ((state_q == S_IDLE) && start),
    .adv_i  (active),
    .vec_i  (op_q),
    .base_i (addr_q),
    .k_o    (k),
    .addr_o (beat_addr),
    .be_o   (beat_be),
    .last_o (last)
  );

  // Beat k covers items k*P.. of the snapshot, so shifting the snapshot down aligns lane 0.
  assign wd_beat = PL'(wd_q >> (int'(k) * PL));

  for (genvar j = 0; j < P; j++) begin : g_lane
    assign mem_wdata[j*L +: L] = (state_q == S_WRITE && beat_be[j]) ? wd_beat[j*L +: L] : '0;
    assign rd_m[j*L +: L]      = cap_be_q[j] ? mem_rdata[j*L +: L] : '0;
    assign lane_m[j*L +: L]    = {L{cap_be_q[j]}};
  end

  // Read data lags its address by one cycle, so merge using the previous beat's index/mask.
  assign vec_d = (vec_q & ~(IL'(lane_m) << (int'(cap_k_q) * PL)))
               | (IL'(rd_m) << (int'(cap_k_q) * PL));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_SCALAR;
      addr_q    <= '0;
      wd_q      <= '0;
      vec_q     <= '0;
      sca_q     <= '0;
      busy_q    <= 1'b0;
      fin_q     <= 1'b0;
      cap_vld_q <= 1'b0;
      cap_k_q   <= '0;
      cap_be_q  <= '0;
    end else begin
      cap_vld_q <= (state_q == S_READ);
      cap_k_q   <= k;
      cap_be_q  <= beat_be;
      if (cap_vld_q) begin
        if (op_q == OP_VECTOR) vec_q <= vec_d;
        else                   sca_q <= mem_rdata[L-1:0];
      end
      fin_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (start) begin
          op_q   <= op_type;
          addr_q <= address;
          busy_q <= 1'b1;
          if (op_type == OP_VECTOR)
            wd_q <= (op_source == SRC_ALU) ? aluResultV : rd2_vec;
          else
            wd_q <= IL'((op_source == SRC_ALU) ? aluResultS : rd2_sca);
          state_q <= write_enable ? S_WRITE : S_READ;
        end
        S_WRITE: if (last) begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          fin_q   <= 1'b1;
        end
        S_READ: if (last) state_q <= S_DRAIN;
        S_DRAIN: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          fin_q   <= 1'b1;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr      = active ? beat_addr : '0;
  assign mem_be        = active ? beat_be : '0;
  assign mem_we        = (state_q == S_WRITE);
  assign busy          = busy_q;
  assign mem_finished  = fin_q;
  assign vector_output = vec_q;
  assign scalar_output = sca_q;

endmodule

// File: tb/tb_vec_mem_stage_mp.sv
// Randomized bench: two stage instances (P=4 and P=3) checked against an item-level memory model.
module tb_vec_mem_stage_mp;

  localparam int I = 20;
  localparam int L = 8;
  localparam int A = 6;
  localparam int W = I * L;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           start, op_type, op_source, write_enable;
  logic [A-1:0]   address;
  logic [W-1:0]   aluV, rd2V;
  logic [L-1:0]   aluS, rd2S;

  logic [31:0] rd4, wd4;
  logic [5:0]  ma4;
  logic        we4, bz4, fn4;
  logic [3:0]  be4;
  logic [7:0]  so4;
  logic [W-1:0] vo4;

  logic [23:0] rd3, wd3;
  logic [5:0]  ma3;
  logic        we3, bz3, fn3;
  logic [2:0]  be3;
  logic [7:0]  so3;
  logic [W-1:0] vo3;

  vec_mem_stage_mp #(.I(I), .L(L), .A(A), .P(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .op_type(op_type), .op_source(op_source),
    .write_enable(write_enable), .address(address), .aluResultV(aluV), .rd2_vec(rd2V),
    .aluResultS(aluS), .rd2_sca(rd2S), .mem_rdata(rd4), .mem_addr(ma4), .mem_wdata(wd4),
    .mem_we(we4), .mem_be(be4), .scalar_output(so4), .vector_output(vo4),
    .busy(bz4), .mem_finished(fn4)
  );

  vec_mem_stage_mp #(.I(I), .L(L), .A(A), .P(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .op_type(op_type), .op_source(op_source),
    .write_enable(write_enable), .address(address), .aluResultV(aluV), .rd2_vec(rd2V),
    .aluResultS(aluS), .rd2_sca(rd2S), .mem_rdata(rd3), .mem_addr(ma3), .mem_wdata(wd3),
    .mem_we(we3), .mem_be(be3), .scalar_output(so3), .vector_output(vo3),
    .busy(bz3), .mem_finished(fn3)
  );

  // Beat-wide memories with one-cycle read latency; items within a beat wrap mod 64.
  logic [7:0] m4 [64];
  logic [7:0] m3 [64];
  logic [7:0] rmem [64];

  always @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      rd4[j*8 +: 8] <= m4[ma4 + 6'(j)];
      if (we4 && be4[j]) m4[ma4 + 6'(j)] <= wd4[j*8 +: 8];
    end
    for (int j = 0; j < 3; j++) begin
      rd3[j*8 +: 8] <= m3[ma3 + 6'(j)];
      if (we3 && be3[j]) m3[ma3 + 6'(j)] <= wd3[j*8 +: 8];
    end
  end

  int         PP [2] = '{4, 3};
  logic [5:0] g_ma [2];
  logic       g_we [2];
  logic       g_bz [2];
  logic       g_fn [2];
  logic [3:0] g_be [2];
  logic [31:0] g_wd [2];
  logic [7:0] g_so [2];
  logic [W-1:0] g_vo [2];

  assign g_ma[0] = ma4;  assign g_ma[1] = ma3;
  assign g_we[0] = we4;  assign g_we[1] = we3;
  assign g_bz[0] = bz4;  assign g_bz[1] = bz3;
  assign g_fn[0] = fn4;  assign g_fn[1] = fn3;
  assign g_be[0] = be4;  assign g_be[1] = {1'b0, be3};
  assign g_wd[0] = wd4;  assign g_wd[1] = {8'h00, wd3};
  assign g_so[0] = so4;  assign g_so[1] = so3;
  assign g_vo[0] = vo4;  assign g_vo[1] = vo3;

  logic [W-1:0] vexp;
  logic [7:0]   sexp;
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int mism(input int d);
    int n;
    n = 0;
    for (int j = 0; j < 64; j++)
      if (((d == 0) ? m4[j] : m3[j]) !== rmem[j]) n++;
    return n;
  endfunction

  task automatic scramble();
    aluV = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    rd2V = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    aluS = 8'($urandom());
    rd2S = 8'($urandom());
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_we_p%0d", tag, PP[d]), W'(g_we[d]), W'(0));
      chk($sformatf("%s_busy_p%0d", tag, PP[d]), W'(g_bz[d]), W'(0));
      chk($sformatf("%s_fin_p%0d", tag, PP[d]), W'(g_fn[d]), W'(0));
      chk($sformatf("%s_addr_p%0d", tag, PP[d]), W'(g_ma[d]), W'(0));
      chk($sformatf("%s_be_p%0d", tag, PP[d]), W'(g_be[d]), W'(0));
      chk($sformatf("%s_vout_p%0d", tag, PP[d]), g_vo[d], W'(0));
      chk($sformatf("%s_sout_p%0d", tag, PP[d]), W'(g_so[d]), W'(0));
    end
  endtask

  // One transaction on both instances; expectations come from item-level rules only.
  task automatic do_op(input bit vec, input bit src, input bit we, input logic [5:0] adr, input bit spur);
    logic [7:0] itm [I];
    logic [3:0] ebe;
    logic [31:0] ewd;
    int nit, n, dn, dmax, dmin, p, ix;
    nit = vec ? I : 1;
    for (int i = 0; i < I; i++)
      itm[i] = vec ? (src ? aluV[i*8 +: 8] : rd2V[i*8 +: 8]) : ((i == 0) ? (src ? aluS : rd2S) : 8'h00);
    dmax = 0;
    dmin = 1000;
    for (int d = 0; d < 2; d++) begin
      n  = vec ? (I + PP[d] - 1) / PP[d] : 1;
      dn = we ? n + 1 : n + 2;
      if (dn > dmax) dmax = dn;
      if (dn < dmin) dmin = dn;
    end
    @(negedge clk);
    op_type = vec; op_source = src; write_enable = we; address = adr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    address = 6'($urandom());
    for (int c = 1; c <= dmax + 1; c++) begin
      if (c > 1) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        p  = PP[d];
        n  = vec ? (I + p - 1) / p : 1;
        dn = we ? n + 1 : n + 2;
        if (c <= dn) begin
          chk($sformatf("busy_p%0d_c%0d", p, c), W'(g_bz[d]), W'(c < dn));
          chk($sformatf("fin_p%0d_c%0d", p, c), W'(g_fn[d]), W'(c == dn));
          chk($sformatf("we_p%0d_c%0d", p, c), W'(g_we[d]), W'(we && c <= n));
        end else begin
          chk($sformatf("idle_busy_p%0d_c%0d", p, c), W'(g_bz[d]), W'(0));
          chk($sformatf("idle_fin_p%0d_c%0d", p, c), W'(g_fn[d]), W'(0));
        end
        if (c <= n) begin
          ebe = '0;
          ewd = '0;
          for (int j = 0; j < p; j++) begin
            ix = (c - 1) * p + j;
            if (ix < nit) begin
              ebe[j] = 1'b1;
              ewd[j*8 +: 8] = itm[ix];
            end
          end
          chk($sformatf("addr_p%0d_c%0d", p, c), W'(g_ma[d]), W'(6'(adr + (c - 1) * p)));
          chk($sformatf("be_p%0d_c%0d", p, c), W'(g_be[d]), W'(ebe));
          if (we) chk($sformatf("wdata_p%0d_c%0d", p, c), W'(g_wd[d]), W'(ewd));
        end
      end
      start = spur && (c == 2 || c == dmin);
      write_enable = 1'($urandom());
      op_type = 1'($urandom());
    end
    start = 1'b0;
    if (we) begin
      for (int i = 0; i < nit; i++) rmem[6'(adr + i)] = itm[i];
    end else if (vec) begin
      for (int i = 0; i < I; i++) vexp[i*8 +: 8] = rmem[6'(adr + i)];
    end else begin
      sexp = rmem[adr];
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("mem_bad_items_p%0d", PP[d]), W'(mism(d)), W'(0));
      chk($sformatf("vout_p%0d", PP[d]), g_vo[d], vexp);
      chk($sformatf("sout_p%0d", PP[d]), W'(g_so[d]), W'(sexp));
    end
  endtask

  // Reset lands in the second beat of a vector store; everything must drop at once.
  task automatic abort_test(input logic [5:0] adr);
    @(negedge clk);
    op_type = 1'b1; op_source = 1'b1; write_enable = 1'b1; address = adr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("abort");
    vexp = '0;
    sexp = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("post_abort_fin_p%0d_c%0d", PP[d], c), W'(g_fn[d]), W'(0));
        chk($sformatf("post_abort_busy_p%0d_c%0d", PP[d], c), W'(g_bz[d]), W'(0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    for (int j = 0; j < 64; j++) begin
      v = 8'($urandom());
      m4[j] = v; m3[j] = v; rmem[j] = v;
    end
    rd4 = '0; rd3 = '0;
    vexp = '0; sexp = '0;
    rst = 1'b0; start = 1'b0; op_type = 1'b0; op_source = 1'b0; write_enable = 1'b0;
    address = '0;
    scramble();
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < I; i++) aluV[i*8 +: 8] = 8'(i + 1);
    do_op(1'b1, 1'b1, 1'b1, 6'd8, 1'b0);
    do_op(1'b1, 1'b0, 1'b0, 6'd8, 1'b1);
    chk("vload_item0", W'(vo4[7:0]), W'(8'd1));
    chk("vload_item19", W'(vo4[159:152]), W'(8'd20));
    scramble();
    do_op(1'b1, 1'b0, 1'b1, 6'd0, 1'b0);
    scramble();
    do_op(1'b1, 1'b1, 1'b1, 6'd62, 1'b1);
    do_op(1'b1, 1'b1, 1'b0, 6'd62, 1'b0);
    rd2S = 8'hA5;
    do_op(1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
    do_op(1'b0, 1'b1, 1'b0, 6'd5, 1'b1);
    chk("sload_a5", W'(so4), W'(8'hA5));
    do_op(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    abort_test(6'd40);
    scramble();
    do_op(1'b1, 1'b1, 1'b1, 6'd40, 1'b1);

    for (int t = 0; t < 40; t++) begin
      scramble();
      do_op(1'($urandom()), 1'($urandom()), 1'($urandom()), 6'($urandom()), 1'($urandom()));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
